// File: rtl/mem_multiport_bank_arbiter.sv
// ---------------------------------------------------------------------------
// mem_multiport_bank_arbiter
//
// Per-bank arbiter that multiplexes NumPorts memory-stream masters onto
// NumBanks SRAM banks. Each bank has its own independent arbiter, which picks
// one requesting port per cycle. A small tracking FIFO per bank remembers
// which port issued every granted request, so that each in-order response
// (mem_rvalid_i) is steered back to the port that issued it.
//
// Ports (p = port, b = bank):
//   clk_i, rst_i      clock, asynchronous active-high reset
//   busy_o            some bank still has a granted request awaiting rvalid
//   err_o[b]          sticky: rvalid arrived with nothing outstanding on bank b
//   port_*_i[p][b]    request side: req, addr, wdata, strb, we, atop
//   port_gnt_o[p][b]  request accepted this cycle
//   port_rvalid_o     response valid, routed to the issuing port
//   port_rdata_o      bank read data, broadcast to every port
//   mem_*_o[b]        winning request presented to bank b
//   mem_gnt_i[b]      bank accepts the presented request
//   mem_rvalid_i[b]   one response per granted request, in order
//   mem_rdata_i[b]    bank read data
//
// The request path is purely combinational (zero latency). Only the RR
// pointer, the lock state, the tracking FIFO and the error flag are state.
// ---------------------------------------------------------------------------
module mem_multiport_bank_arbiter #(
    parameter int NumPorts       = 2,
    parameter int NumBanks       = 4,
    parameter int AddrWidth      = 32,
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2,
    parameter int ArbMode        = 0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    output logic                                              busy_o,
    output logic [NumBanks-1:0]                               err_o,
    input  logic [NumPorts-1:0][NumBanks-1:0]                 port_req_i,
    output logic [NumPorts-1:0][NumBanks-1:0]                 port_gnt_o,
    input  logic [NumPorts-1:0][NumBanks-1:0][AddrWidth-1:0]  port_addr_i,
    input  logic [NumPorts-1:0][NumBanks-1:0][DataWidth-1:0]  port_wdata_i,
    input  logic [NumPorts-1:0][NumBanks-1:0][DataWidth/8-1:0] port_strb_i,
    input  logic [NumPorts-1:0][NumBanks-1:0]                 port_we_i,
    input  logic [NumPorts-1:0][NumBanks-1:0][5:0]            port_atop_i,
    output logic [NumPorts-1:0][NumBanks-1:0]                 port_rvalid_o,
    output logic [NumPorts-1:0][NumBanks-1:0][DataWidth-1:0]  port_rdata_o,
    output logic [NumBanks-1:0]                               mem_req_o,
    input  logic [NumBanks-1:0]                               mem_gnt_i,
    output logic [NumBanks-1:0][AddrWidth-1:0]                mem_addr_o,
    output logic [NumBanks-1:0][DataWidth-1:0]                mem_wdata_o,
    output logic [NumBanks-1:0][DataWidth/8-1:0]              mem_strb_o,
    output logic [NumBanks-1:0]                               mem_we_o,
    output logic [NumBanks-1:0][5:0]                          mem_atop_o,
    input  logic [NumBanks-1:0]                               mem_rvalid_i,
    input  logic [NumBanks-1:0][DataWidth-1:0]                mem_rdata_i
);

    localparam int IdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    // Round-robin pick: first requester found scanning upward from ptr,
    // wrapping at NumPorts.
    function automatic logic [IdxWidth-1:0] rr_pick(
        input logic [NumPorts-1:0] req,
        input logic [IdxWidth-1:0] ptr
    );
        logic [IdxWidth-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NumPorts) begin
                idx = idx - NumPorts;
            end
            if (!found && req[idx]) begin
                pick  = IdxWidth'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Fixed priority: lowest requesting index wins.
    function automatic logic [IdxWidth-1:0] fixed_pick(
        input logic [NumPorts-1:0] req
    );
        logic [IdxWidth-1:0] pick;
        pick = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick = IdxWidth'(i);
            end
        end
        return pick;
    endfunction

    logic [NumBanks-1:0] bank_busy;

    assign busy_o = |bank_busy;

    for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
        logic [NumPorts-1:0] req_vec;
        logic [IdxWidth-1:0] winner;
        logic [IdxWidth-1:0] head_idx;
        logic                full;
        logic                mem_req;
        logic                handshake;
        logic                pop;
        logic                fall_through;
        logic                push;
        logic                drop;

        logic [IdxWidth-1:0] rr_ptr_reg;
        logic [IdxWidth-1:0] lock_port_reg;
        logic                lock_valid_reg;
        logic [PtrWidth-1:0] wr_ptr_reg;
        logic [PtrWidth-1:0] rd_ptr_reg;
        logic [CntWidth-1:0] count_reg;
        logic [CntWidth-1:0] count_next;
        logic                err_reg;
        logic [IdxWidth-1:0] fifo_mem [MaxOutstanding];

        for (genvar gp = 0; gp < NumPorts; gp++) begin : g_req
            assign req_vec[gp] = port_req_i[gp][gi];
        end

        // A locked winner keeps the bank while it still requests, so a
        // stalled payload is never swapped under the bank's feet.
        always_comb begin
            winner = '0;
            if (lock_valid_reg && req_vec[lock_port_reg]) begin
                winner = lock_port_reg;
            end else if (ArbMode == 1) begin
                winner = fixed_pick(req_vec);
            end else begin
                winner = rr_pick(req_vec, rr_ptr_reg);
            end
        end

        // An rvalid in the same cycle frees a slot, so a full FIFO can still
        // accept a new request while it drains one.
        assign full         = (count_reg == CntWidth'(MaxOutstanding)) && !mem_rvalid_i[gi];
        assign mem_req      = (|req_vec) && !full;
        assign handshake    = mem_req && mem_gnt_i[gi];
        assign pop          = mem_rvalid_i[gi] && (count_reg != '0);
        // Empty FIFO: a same-cycle response belongs to the request being
        // granted right now, so it bypasses the FIFO entirely.
        assign fall_through = mem_rvalid_i[gi] && (count_reg == '0) && handshake;
        assign push         = handshake && !fall_through;
        assign drop         = mem_rvalid_i[gi] && (count_reg == '0) && !handshake;
        assign head_idx     = fifo_mem[rd_ptr_reg];

        assign mem_req_o[gi]   = mem_req;
        assign mem_addr_o[gi]  = port_addr_i[winner][gi];
        assign mem_wdata_o[gi] = port_wdata_i[winner][gi];
        assign mem_strb_o[gi]  = port_strb_i[winner][gi];
        assign mem_we_o[gi]    = port_we_i[winner][gi];
        assign mem_atop_o[gi]  = port_atop_i[winner][gi];

        for (genvar gp = 0; gp < NumPorts; gp++) begin : g_port
            assign port_gnt_o[gp][gi]    = handshake && (winner == IdxWidth'(gp));
            assign port_rvalid_o[gp][gi] = (pop && (head_idx == IdxWidth'(gp)))
                                        || (fall_through && (winner == IdxWidth'(gp)));
            assign port_rdata_o[gp][gi]  = mem_rdata_i[gi];
        end

        always_comb begin
            count_next = count_reg;
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rr_ptr_reg     <= '0;
                lock_port_reg  <= '0;
                lock_valid_reg <= 1'b0;
                wr_ptr_reg     <= '0;
                rd_ptr_reg     <= '0;
                count_reg      <= '0;
                err_reg        <= 1'b0;
            end else begin
                lock_valid_reg <= mem_req && !mem_gnt_i[gi];
                lock_port_reg  <= winner;
                if (handshake) begin
                    rr_ptr_reg <= (winner == IdxWidth'(NumPorts - 1)) ? '0 : winner + 1'b1;
                end
                if (push) begin
                    wr_ptr_reg <= (wr_ptr_reg == PtrWidth'(MaxOutstanding - 1)) ? '0
                                                                                 : wr_ptr_reg + 1'b1;
                end
                if (pop) begin
                    rd_ptr_reg <= (rd_ptr_reg == PtrWidth'(MaxOutstanding - 1)) ? '0
                                                                                 : rd_ptr_reg + 1'b1;
                end
                count_reg <= count_next;
                if (drop) begin
                    err_reg <= 1'b1;
                end
            end
        end

        // Storage needs no reset: entries are only read while count_reg says
        // they are valid.
        always_ff @(posedge clk_i) begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= winner;
            end
        end

        assign err_o[gi]     = err_reg;
        assign bank_busy[gi] = (count_reg != '0);
    end

endmodule
